// File: rtl/mbus_ice_driver_tx_gen.sv
// ICE-to-MBus transmit driver: packs the bus-interface char stream into an MBus address
// word and data words, then runs the txreq/txack/txsucc handshake with timeout and ACK/NAK.
module mbus_ice_driver_tx_gen #(
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned SHORT_ADDR_EN  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_frame_valid,
    input  logic                    tx_char_valid,
    input  logic [7:0]              tx_char,
    input  logic                    tx_char_pending,
    output logic                    tx_char_advance,
    output logic [31:0]             tx_mbus_txaddr,
    output logic [8*DATA_BYTES-1:0] tx_mbus_txdata,
    output logic [3:0]              tx_mbus_txbytes,
    output logic                    tx_mbus_txreq,
    output logic                    tx_mbus_txpend,
    input  logic                    tx_mbus_txack,
    input  logic                    tx_mbus_txfail,
    input  logic                    tx_mbus_txsucc,
    output logic                    tx_mbus_txresp_ack,
    output logic                    tx_gen_ack,
    output logic                    tx_gen_nak,
    input  logic                    tx_acknak_valid,
    output logic                    tx_timeout,
    output logic [CNT_W-1:0]        tx_word_cnt
);

    localparam int unsigned DW    = 8 * DATA_BYTES;
    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_ADDR_IDX = IDX_W'(3);
    localparam logic [TO_W-1:0]  TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic             TO_EN         = (TIMEOUT_CYCLES != 0);
    localparam logic             SHORT_EN      = (SHORT_ADDR_EN != 0);
    localparam logic [5:0]       FULL_SHIFT    = 6'(8 * (DATA_BYTES - 1));

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WAIT, S_TXREQ, S_TXACK, S_TXSUCC, S_RESULT
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               first_word, first_word_nxt;
    logic [31:0]        addr_nxt;
    logic [DW-1:0]      data_nxt;
    logic [3:0]         bytes_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic [DW-1:0]      data_shift;
    logic [5:0]         pad_shift;
    logic               to_hit;

    // Data word with the incoming char appended in the LSByte; pad shift left-aligns a short final word.
    assign data_shift = DW'({tx_mbus_txdata, tx_char});
    assign pad_shift  = FULL_SHIFT - {idx, 3'b000};
    assign to_hit     = TO_EN && (to_cnt == TO_LAST);

    always_comb begin
        state_nxt          = state;
        idx_nxt            = idx;
        first_word_nxt     = first_word;
        addr_nxt           = tx_mbus_txaddr;
        data_nxt           = tx_mbus_txdata;
        bytes_nxt          = tx_mbus_txbytes;
        cnt_nxt            = tx_word_cnt;
        to_cnt_nxt         = to_cnt;
        tx_char_advance    = 1'b0;
        tx_mbus_txreq      = 1'b0;
        tx_mbus_txpend     = 1'b0;
        tx_mbus_txresp_ack = 1'b0;
        tx_gen_ack         = 1'b0;
        tx_gen_nak         = 1'b0;
        tx_timeout         = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_frame_valid) begin
                    state_nxt      = S_ADDR;
                    idx_nxt        = '0;
                    first_word_nxt = 1'b1;
                end
            end
            S_ADDR: begin
                tx_char_advance = tx_char_valid;
                if (tx_char_valid) begin
                    if ((idx == '0) && SHORT_EN && (tx_char[7:4] != 4'hF)) begin
                        addr_nxt  = {24'h0, tx_char};
                        state_nxt = S_DATA;
                        idx_nxt   = '0;
                    end else begin
                        addr_nxt = {tx_mbus_txaddr[23:0], tx_char};
                        if (idx == LAST_ADDR_IDX) begin
                            state_nxt = S_DATA;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = IDX_W'(idx + 1'b1);
                        end
                    end
                end else if (first_word && !tx_frame_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                tx_char_advance = tx_char_valid;
                if (tx_char_valid) begin
                    if (idx == LAST_DATA_IDX) begin
                        data_nxt  = data_shift;
                        bytes_nxt = 4'(DATA_BYTES);
                        state_nxt = S_WAIT;
                    end else if (!tx_char_pending) begin
                        data_nxt  = data_shift << pad_shift;
                        bytes_nxt = 4'(idx) + 4'd1;
                        state_nxt = S_WAIT;
                    end else begin
                        data_nxt = data_shift;
                        idx_nxt  = IDX_W'(idx + 1'b1);
                    end
                end else if (first_word && !tx_frame_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                to_cnt_nxt = '0;
                state_nxt  = S_TXREQ;
            end
            S_TXREQ: begin
                tx_mbus_txreq  = 1'b1;
                tx_mbus_txpend = tx_char_pending;
                if (tx_mbus_txack) begin
                    state_nxt      = S_TXACK;
                    cnt_nxt        = CNT_W'(tx_word_cnt + 1'b1);
                    first_word_nxt = 1'b0;
                end else if (to_hit) begin
                    tx_timeout = 1'b1;
                    tx_gen_nak = 1'b1;
                    state_nxt  = S_RESULT;
                end else begin
                    to_cnt_nxt = TO_W'(to_cnt + 1'b1);
                end
            end
            S_TXACK: begin
                if (!tx_mbus_txack) begin
                    if (tx_char_pending) begin
                        state_nxt = S_DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt  = S_TXSUCC;
                        to_cnt_nxt = '0;
                    end
                end
            end
            S_TXSUCC: begin
                // Success outranks failure, and any real response outranks the timeout.
                if (tx_mbus_txsucc) begin
                    tx_gen_ack = 1'b1;
                    state_nxt  = S_RESULT;
                end else if (tx_mbus_txfail) begin
                    tx_gen_nak = 1'b1;
                    state_nxt  = S_RESULT;
                end else if (to_hit) begin
                    tx_timeout = 1'b1;
                    tx_gen_nak = 1'b1;
                    state_nxt  = S_RESULT;
                end else begin
                    to_cnt_nxt = TO_W'(to_cnt + 1'b1);
                end
            end
            S_RESULT: begin
                tx_mbus_txresp_ack = 1'b1;
                if (!tx_acknak_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            idx             <= '0;
            first_word      <= 1'b0;
            tx_mbus_txaddr  <= '0;
            tx_mbus_txdata  <= '0;
            tx_mbus_txbytes <= '0;
            tx_word_cnt     <= '0;
            to_cnt          <= '0;
        end else begin
            state           <= state_nxt;
            idx             <= idx_nxt;
            first_word      <= first_word_nxt;
            tx_mbus_txaddr  <= addr_nxt;
            tx_mbus_txdata  <= data_nxt;
            tx_mbus_txbytes <= bytes_nxt;
            tx_word_cnt     <= cnt_nxt;
            to_cnt          <= to_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mbus_ice_driver_tx_gen.sv
// Directed bench for mbus_ice_driver_tx_gen: a 4-byte-word instance and a 2-byte-word instance
// share stimulus; a cycle table covers a long-address frame, hand sequences cover the corners.
module tb_mbus_ice_driver_tx_gen;

    logic       clk;
    logic       reset;
    logic       frame_valid, char_valid, char_pending;
    logic [7:0] char_in;
    logic       txack, txfail, txsucc, acknak_valid;

    logic        d4_adv, d4_req, d4_pend, d4_resp, d4_gack, d4_gnak, d4_to;
    logic [31:0] d4_addr, d4_data;
    logic [3:0]  d4_bytes;
    logic [15:0] d4_cnt;
    logic        d2_adv, d2_req, d2_pend, d2_resp, d2_gack, d2_gnak, d2_to;
    logic [31:0] d2_addr;
    logic [15:0] d2_data;
    logic [3:0]  d2_bytes;
    logic [15:0] d2_cnt;

    logic        sel;
    logic        v_adv, v_req, v_pend, v_resp, v_gack, v_gnak, v_to;
    logic [31:0] v_addr, v_data;
    logic [3:0]  v_bytes;
    logic [15:0] v_cnt;

    int total = 0;
    int bad   = 0;

    mbus_ice_driver_tx_gen #(.DATA_BYTES(4), .SHORT_ADDR_EN(1), .TIMEOUT_CYCLES(16),
                             .TO_W(16), .CNT_W(16)) u_dut4 (
        .clk(clk), .reset(reset), .tx_frame_valid(frame_valid), .tx_char_valid(char_valid),
        .tx_char(char_in), .tx_char_pending(char_pending), .tx_char_advance(d4_adv),
        .tx_mbus_txaddr(d4_addr), .tx_mbus_txdata(d4_data), .tx_mbus_txbytes(d4_bytes),
        .tx_mbus_txreq(d4_req), .tx_mbus_txpend(d4_pend), .tx_mbus_txack(txack),
        .tx_mbus_txfail(txfail), .tx_mbus_txsucc(txsucc), .tx_mbus_txresp_ack(d4_resp),
        .tx_gen_ack(d4_gack), .tx_gen_nak(d4_gnak), .tx_acknak_valid(acknak_valid),
        .tx_timeout(d4_to), .tx_word_cnt(d4_cnt)
    );

    mbus_ice_driver_tx_gen #(.DATA_BYTES(2), .SHORT_ADDR_EN(1), .TIMEOUT_CYCLES(16),
                             .TO_W(16), .CNT_W(16)) u_dut2 (
        .clk(clk), .reset(reset), .tx_frame_valid(frame_valid), .tx_char_valid(char_valid),
        .tx_char(char_in), .tx_char_pending(char_pending), .tx_char_advance(d2_adv),
        .tx_mbus_txaddr(d2_addr), .tx_mbus_txdata(d2_data), .tx_mbus_txbytes(d2_bytes),
        .tx_mbus_txreq(d2_req), .tx_mbus_txpend(d2_pend), .tx_mbus_txack(txack),
        .tx_mbus_txfail(txfail), .tx_mbus_txsucc(txsucc), .tx_mbus_txresp_ack(d2_resp),
        .tx_gen_ack(d2_gack), .tx_gen_nak(d2_gnak), .tx_acknak_valid(acknak_valid),
        .tx_timeout(d2_to), .tx_word_cnt(d2_cnt)
    );

    always_comb begin
        if (sel) begin
            {v_adv, v_req, v_pend, v_resp, v_gack, v_gnak, v_to} =
                {d2_adv, d2_req, d2_pend, d2_resp, d2_gack, d2_gnak, d2_to};
            v_addr  = d2_addr;
            v_data  = 32'(d2_data);
            v_bytes = d2_bytes;
            v_cnt   = d2_cnt;
        end else begin
            {v_adv, v_req, v_pend, v_resp, v_gack, v_gnak, v_to} =
                {d4_adv, d4_req, d4_pend, d4_resp, d4_gack, d4_gnak, d4_to};
            v_addr  = d4_addr;
            v_data  = d4_data;
            v_bytes = d4_bytes;
            v_cnt   = d4_cnt;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       fv, cv;
        logic [7:0] ch;
        logic       pend, ack, succ, fail, akv;
        logic [5:0] exp;   // {advance, txreq, txpend, txresp_ack, gen_ack, gen_nak}
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic fv, input logic cv, input logic [7:0] ch,
                                input logic pend, input logic ack, input logic succ,
                                input logic fail, input logic akv, input logic [5:0] exp);
        vec_t v;
        v.fv = fv; v.cv = cv; v.ch = ch; v.pend = pend; v.ack = ack;
        v.succ = succ; v.fail = fail; v.akv = akv; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_valid = 1'b0; char_valid = 1'b0; char_in = 8'h00; char_pending = 1'b0;
        txack = 1'b0; txfail = 1'b0; txsucc = 1'b0; acknak_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_char(input logic [7:0] c, input logic pend);
        char_valid = 1'b1; char_in = c; char_pending = pend;
        @(negedge clk);
        chk("advance", 32'(v_adv), 32'd1);
        step();
        char_valid = 1'b0;
    endtask

    // Returns at the negedge of the first txreq cycle; lat is the cycle count until then.
    task automatic wait_req(output int lat);
        lat = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (v_req) begin
                lat = i;
                break;
            end
            step();
        end
        if (lat < 0) chk("txreq_seen", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int reqs;
        logic [7:0] c0, c1;
        logic last;

        sel = 1'b0;
        idle_inputs();
        reset = 1'b0;
        #12;
        chk("rst_txaddr", v_addr, 32'h0);
        chk("rst_txdata", v_data, 32'h0);
        chk("rst_txbytes", 32'(v_bytes), 32'd0);
        chk("rst_wordcnt", 32'(v_cnt), 32'd0);
        chk("rst_hs", 32'({v_adv, v_req, v_pend, v_resp, v_gack, v_gnak, v_to}), 32'd0);
        do_reset();

        // Long-address frame F0 12 34 56 / AA BB CC DD, one cycle per row.
        vecs[0]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 6'b000000);
        vecs[1]  = mk(1, 1, 8'hF0, 1, 0, 0, 0, 0, 6'b100000);
        vecs[2]  = mk(1, 1, 8'h12, 1, 0, 0, 0, 0, 6'b100000);
        vecs[3]  = mk(1, 1, 8'h34, 1, 0, 0, 0, 0, 6'b100000);
        vecs[4]  = mk(1, 1, 8'h56, 1, 0, 0, 0, 0, 6'b100000);
        vecs[5]  = mk(1, 1, 8'hAA, 1, 0, 0, 0, 0, 6'b100000);
        vecs[6]  = mk(1, 1, 8'hBB, 1, 0, 0, 0, 0, 6'b100000);
        vecs[7]  = mk(1, 1, 8'hCC, 1, 0, 0, 0, 0, 6'b100000);
        vecs[8]  = mk(1, 1, 8'hDD, 0, 0, 0, 0, 0, 6'b100000);
        vecs[9]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 6'b000000);
        vecs[10] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 6'b010000);
        vecs[11] = mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 6'b010000);
        vecs[12] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 6'b000000);
        vecs[13] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 6'b000000);
        vecs[14] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 6'b000010);
        vecs[15] = mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 6'b000100);
        vecs[16] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 6'b000100);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 6'b000000);

        for (int i = 0; i < 18; i++) begin
            frame_valid = vecs[i].fv; char_valid = vecs[i].cv; char_in = vecs[i].ch;
            char_pending = vecs[i].pend; txack = vecs[i].ack; txsucc = vecs[i].succ;
            txfail = vecs[i].fail; acknak_valid = vecs[i].akv;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                32'({v_adv, v_req, v_pend, v_resp, v_gack, v_gnak}), 32'(vecs[i].exp));
            if (i == 10) begin
                chk("long_txaddr", v_addr, 32'hF012_3456);
                chk("long_txdata", v_data, 32'hAABB_CCDD);
                chk("long_txbytes", 32'(v_bytes), 32'd4);
            end
            step();
        end
        chk("long_hold_txaddr", v_addr, 32'hF012_3456);
        chk("long_wordcnt", 32'(v_cnt), 32'd1);

        // Short address, partial final word, succ+fail together.
        do_reset();
        sel = 1'b0;
        frame_valid = 1'b1;
        step();
        send_char(8'h25, 1'b1);
        send_char(8'h01, 1'b1);
        send_char(8'h02, 1'b0);
        frame_valid = 1'b0;
        wait_req(lat);
        chk("short_latency", 32'(lat), 32'd1);
        chk("short_txaddr", v_addr, 32'h0000_0025);
        chk("short_txdata", v_data, 32'h0102_0000);
        chk("short_txbytes", 32'(v_bytes), 32'd2);
        chk("short_txpend", 32'(v_pend), 32'd0);
        txack = 1'b1;
        step();
        txack = 1'b0;
        step();
        txsucc = 1'b1; txfail = 1'b1;
        @(negedge clk);
        chk("both_gen_ack", 32'(v_gack), 32'd1);
        chk("both_gen_nak", 32'(v_gnak), 32'd0);
        step();
        txsucc = 1'b0; txfail = 1'b0;
        @(negedge clk);
        chk("short_resp_ack", 32'(v_resp), 32'd1);
        step();
        @(negedge clk);
        chk("short_idle_resp", 32'(v_resp), 32'd0);
        step();

        // Multi-word frame on the 2-byte instance.
        do_reset();
        sel = 1'b1;
        reqs = 0;
        frame_valid = 1'b1;
        step();
        send_char(8'h25, 1'b1);
        for (int w = 0; w < 4; w++) begin
            last = (w == 3);
            c0 = 8'(2 * w + 1);
            c1 = 8'(2 * w + 2);
            send_char(c0, 1'b1);
            send_char(c1, !last);
            char_pending = !last;
            wait_req(lat);
            if (lat >= 0) reqs++;
            chk($sformatf("mw%0d_txpend", w), 32'(v_pend), 32'(!last));
            chk($sformatf("mw%0d_txdata", w), v_data, {16'h0, c0, c1});
            chk($sformatf("mw%0d_txbytes", w), 32'(v_bytes), 32'd2);
            step();
            txack = 1'b1;
            step();
            txack = 1'b0;
            frame_valid = 1'b0;
            step();
        end
        chk("mw_reqs", 32'(reqs), 32'd4);
        chk("mw_wordcnt", 32'(v_cnt), 32'd4);
        txsucc = 1'b1;
        @(negedge clk);
        chk("mw_gen_ack", 32'(v_gack), 32'd1);
        step();
        txsucc = 1'b0;
        @(negedge clk);
        chk("mw_result_gen_ack", 32'(v_gack), 32'd0);
        step();

        // Handshake timeout: txack never comes.
        do_reset();
        sel = 1'b0;
        frame_valid = 1'b1;
        step();
        send_char(8'h25, 1'b1);
        send_char(8'h11, 1'b0);
        frame_valid = 1'b0;
        wait_req(lat);
        chk("to_txdata", v_data, 32'h1100_0000);
        chk("to_txbytes", 32'(v_bytes), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("to_pulse_c%0d", i), 32'(v_to), 32'(i == 15));
            chk($sformatf("to_nak_c%0d", i), 32'(v_gnak), 32'(i == 15));
            if (i < 15) chk($sformatf("to_req_c%0d", i), 32'(v_req), 32'd1);
            step();
        end
        @(negedge clk);
        chk("to_result_resp", 32'(v_resp), 32'd1);
        chk("to_result_req", 32'(v_req), 32'd0);
        chk("to_result_pulse", 32'(v_to), 32'd0);
        step();
        @(negedge clk);
        chk("to_idle_resp", 32'(v_resp), 32'd0);
        chk("to_wordcnt", 32'(v_cnt), 32'd0);
        step();

        // Abort after two long-address chars.
        do_reset();
        sel = 1'b0;
        frame_valid = 1'b1;
        step();
        send_char(8'hF0, 1'b1);
        send_char(8'h12, 1'b1);
        frame_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (v_req || v_gack || v_gnak) lat++;
            step();
        end
        chk("abort_no_req", 32'(lat), 32'd0);
        char_valid = 1'b1; char_in = 8'h33;
        @(negedge clk);
        chk("abort_idle_no_adv", 32'(v_adv), 32'd0);
        step();
        char_valid = 1'b0;

        // Reset while requesting.
        do_reset();
        sel = 1'b0;
        frame_valid = 1'b1;
        step();
        send_char(8'h25, 1'b1);
        send_char(8'h44, 1'b0);
        frame_valid = 1'b0;
        wait_req(lat);
        chk("pre_rst_req", 32'(v_req), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(v_req), 32'd0);
        chk("mid_rst_txaddr", v_addr, 32'h0);
        chk("mid_rst_txbytes", 32'(v_bytes), 32'd0);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_req", 32'(v_req), 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
